// File: rtl/sdram_responder_if.sv
// ============================================================================
// Module   : sdram_responder_if
// Purpose  : SDR SDRAM command/address pins plus responder status outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sdram_responder_if #(
    parameter int ROW_WIDTH     = 13,
    parameter int COL_WIDTH     = 9,
    parameter int BANK_WIDTH    = 2,
    parameter int SDRADDR_WIDTH = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH
);
    logic [SDRADDR_WIDTH-1:0] addr;
    logic [BANK_WIDTH-1:0]    bank_addr;
    logic                     clock_enable;
    logic                     cs_n;
    logic                     ras_n;
    logic                     cas_n;
    logic                     we_n;
    logic                     data_mask_low;
    logic                     data_mask_high;
    logic                     init_done;
    logic [1:0]               cas_latency;
    logic [7:0]               error_flags;

    modport master (
        output addr, bank_addr, clock_enable, cs_n, ras_n, cas_n, we_n,
               data_mask_low, data_mask_high,
        input  init_done, cas_latency, error_flags
    );

    modport slave (
        input  addr, bank_addr, clock_enable, cs_n, ras_n, cas_n, we_n,
               data_mask_low, data_mask_high,
        output init_done, cas_latency, error_flags
    );
endinterface

`default_nettype wire

// File: rtl/sdram_responder.sv
// ============================================================================
// Module   : sdram_responder
// Purpose  : SDR SDRAM device emulator with CAS-latency reads and sticky
//            protocol/timing violation flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sdram_responder #(
    parameter int ROW_WIDTH          = 13,
    parameter int COL_WIDTH          = 9,
    parameter int BANK_WIDTH         = 2,
    parameter int SDRADDR_WIDTH      = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
    parameter int MEM_ADDR_WIDTH     = 10,
    parameter int TRCD               = 2,
    parameter int REFRESH_MAX_CYCLES = 1000,
    parameter int INIT_REF_MIN       = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sdram_responder_if.slave   bus,
    inout  wire  [15:0]        data
);
    localparam int NBANK  = 1 << BANK_WIDTH;
    localparam int AGE_W  = $clog2(TRCD + 1);
    localparam int REF_W  = $clog2(REFRESH_MAX_CYCLES + 1);
    localparam int IREF_W = $clog2(INIT_REF_MIN + 1);
    localparam int FULL_W = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

    typedef enum logic [1:0] {
        S_UNINIT     = 2'd0,
        S_PRECHARGED = 2'd1,
        S_REFRESHED  = 2'd2,
        S_READY      = 2'd3
    } state_t;

    state_t                r_state;
    logic [IREF_W-1:0]     r_init_ref;
    logic                  r_init_done;
    logic [1:0]            r_cl;
    logic [7:0]            r_err;
    logic [NBANK-1:0]      r_open;
    logic [ROW_WIDTH-1:0]  r_row [NBANK];
    logic [AGE_W-1:0]      r_age [NBANK];
    logic [REF_W-1:0]      r_ref_cnt;
    logic [2:0]            r_v;
    logic [15:0]           r_pd  [3];
    logic [15:0]           r_mem [1 << MEM_ADDR_WIDTH];

    logic [SDRADDR_WIDTH-1:0] w_addr;
    logic [BANK_WIDTH-1:0]    w_bank;
    logic                     w_cmd_en, w_act, w_read, w_write, w_pre, w_mrs, w_ref;
    logic                     w_bank_open, w_rw_ok, w_a10;
    logic [FULL_W-1:0]        w_full;
    logic [MEM_ADDR_WIDTH-1:0] w_idx;
    logic [15:0]              w_word, w_fetch, w_dout;
    logic                     w_drive, w_pend;
    logic [7:0]               w_err_set;
    logic                     w_unused;

    assign w_addr      = bus.addr;
    assign w_bank      = bus.bank_addr;
    assign w_a10       = w_addr[10];
    assign w_cmd_en    = bus.clock_enable && !bus.cs_n;
    assign w_act       = w_cmd_en && ({bus.ras_n, bus.cas_n, bus.we_n} == 3'b011);
    assign w_read      = w_cmd_en && ({bus.ras_n, bus.cas_n, bus.we_n} == 3'b101);
    assign w_write     = w_cmd_en && ({bus.ras_n, bus.cas_n, bus.we_n} == 3'b100);
    assign w_pre       = w_cmd_en && ({bus.ras_n, bus.cas_n, bus.we_n} == 3'b001);
    assign w_mrs       = w_cmd_en && ({bus.ras_n, bus.cas_n, bus.we_n} == 3'b000);
    assign w_ref       = w_cmd_en && ({bus.ras_n, bus.cas_n, bus.we_n} == 3'b010);
    assign w_bank_open = r_open[w_bank];
    assign w_rw_ok     = (w_read || w_write) && w_bank_open;
    assign w_full      = {w_bank, r_row[w_bank], w_addr[COL_WIDTH-1:0]};
    assign w_idx       = w_full[MEM_ADDR_WIDTH-1:0];
    assign w_word      = r_mem[w_idx];
    assign w_fetch     = {bus.data_mask_high ? 8'h00 : w_word[15:8],
                          bus.data_mask_low  ? 8'h00 : w_word[7:0]};
    assign w_unused    = &{1'b0, w_full, w_addr};

    // Pipeline stage CL-1 owns the bus; earlier stages are still pending.
    always_comb begin
        w_drive = r_v[2];
        w_dout  = r_pd[2];
        w_pend  = |r_v;
        case (r_cl)
            2'd1: begin w_drive = r_v[0]; w_dout = r_pd[0]; w_pend = r_v[0];   end
            2'd2: begin w_drive = r_v[1]; w_dout = r_pd[1]; w_pend = |r_v[1:0]; end
            default: ;
        endcase
    end

    assign data = w_drive ? w_dout : 16'hzzzz;

    always_comb begin
        w_err_set    = '0;
        w_err_set[0] = ((w_act || w_read || w_write) && (r_state != S_READY)) ||
                       (w_ref && (r_state == S_UNINIT));
        w_err_set[1] = w_act && w_bank_open;
        w_err_set[2] = (w_read || w_write) && !w_bank_open;
        w_err_set[3] = w_rw_ok && (r_age[w_bank] < AGE_W'(TRCD));
        w_err_set[4] = (w_ref || w_mrs) && (|r_open);
        w_err_set[5] = w_mrs && (((w_addr[6:4] != 3'd2) && (w_addr[6:4] != 3'd3)) ||
                                 (w_addr[2:0] != 3'd0));
        w_err_set[6] = bus.clock_enable && (r_state == S_READY) &&
                       (r_ref_cnt >= REF_W'(REFRESH_MAX_CYCLES));
        w_err_set[7] = w_write && w_pend;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_UNINIT;
            r_init_ref  <= '0;
            r_init_done <= 1'b0;
            r_cl        <= '0;
            r_err       <= '0;
            r_open      <= '0;
            r_ref_cnt   <= '0;
            r_v         <= '0;
            for (int b = 0; b < NBANK; b++) begin
                r_row[b] <= '0;
                r_age[b] <= '0;
            end
            for (int s = 0; s < 3; s++) r_pd[s] <= '0;
        end else if (bus.clock_enable) begin
            r_err <= r_err | w_err_set;

            for (int b = 0; b < NBANK; b++) begin
                if (r_age[b] != AGE_W'(TRCD)) r_age[b] <= r_age[b] + 1'b1;
            end
            // Age starts at 1 on the ACT edge so it equals cycles elapsed.
            if (w_act) begin
                r_open[w_bank] <= 1'b1;
                r_row[w_bank]  <= w_addr[ROW_WIDTH-1:0];
                r_age[w_bank]  <= AGE_W'(1);
            end
            if (w_pre) begin
                if (w_a10) r_open <= '0;
                else       r_open[w_bank] <= 1'b0;
            end
            if (w_rw_ok && w_a10) r_open[w_bank] <= 1'b0;

            r_v     <= {r_v[1:0], w_read && w_bank_open};
            r_pd[0] <= w_fetch;
            r_pd[1] <= r_pd[0];
            r_pd[2] <= r_pd[1];

            if (w_ref || (w_mrs && r_state == S_REFRESHED))
                r_ref_cnt <= '0;
            else if (r_state == S_READY && r_ref_cnt != REF_W'(REFRESH_MAX_CYCLES))
                r_ref_cnt <= r_ref_cnt + 1'b1;

            if (w_mrs) r_cl <= w_addr[5:4];

            case (r_state)
                S_UNINIT: begin
                    if (w_pre && w_a10) begin
                        r_state    <= S_PRECHARGED;
                        r_init_ref <= '0;
                    end
                end
                S_PRECHARGED: begin
                    if (w_ref) begin
                        r_init_ref <= r_init_ref + 1'b1;
                        if (r_init_ref == IREF_W'(INIT_REF_MIN - 1)) r_state <= S_REFRESHED;
                    end
                end
                S_REFRESHED: begin
                    if (w_mrs) begin
                        r_state     <= S_READY;
                        r_init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_write && w_bank_open) begin
            if (!bus.data_mask_low)  r_mem[w_idx][7:0]  <= data[7:0];
            if (!bus.data_mask_high) r_mem[w_idx][15:8] <= data[15:8];
        end
    end

    assign bus.init_done   = r_init_done;
    assign bus.cas_latency = r_cl;
    assign bus.error_flags = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sdram_responder.sv
// ============================================================================
// Module   : tb_sdram_responder
// Purpose  : Directed scoreboard bench for the SDRAM responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sdram_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tb_dq;
    logic        tb_oe;
    wire  [15:0] dq;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          tb_cl = 0;
    logic        mon_en = 1'b0;

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;
    exp_t exp_q[$];

    sdram_responder_if bus ();

    assign dq = tb_oe ? tb_dq : 16'hzzzz;
    pullup pu_dq (dq);

    sdram_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .data  (dq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a due read word must appear, otherwise the bus must float.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                tests++; fails++;
                $display("FAIL dq_missed: word 0x%04h never sampled, due cycle %0d", exp_q[0].val, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                tests++;
                if (dq !== e.val) begin
                    fails++;
                    $display("FAIL dq_read: cycle %0d got 0x%04h, expected 0x%04h", cyc, dq, e.val);
                end
            end else if (!tb_oe) begin
                tests++;
                if (dq !== 16'hffff) begin
                    fails++;
                    $display("FAIL dq_idle: cycle %0d got 0x%04h, expected high-Z (0xffff pulled)", cyc, dq);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] rcw, input logic [1:0] ba, input logic [12:0] a,
                         input logic [1:0] dqm, input logic drv, input logic [15:0] wd);
        bus.cs_n = 1'b0;
        {bus.ras_n, bus.cas_n, bus.we_n} = rcw;
        bus.bank_addr = ba;
        bus.addr = a;
        {bus.data_mask_high, bus.data_mask_low} = dqm;
        tb_dq = wd;
        tb_oe = drv;
        @(posedge clk); #1;
        bus.cs_n = 1'b1;
        {bus.ras_n, bus.cas_n, bus.we_n} = 3'b111;
        {bus.data_mask_high, bus.data_mask_low} = 2'b00;
        tb_oe = 1'b0;
    endtask

    task automatic nop(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic act(input logic [1:0] ba, input logic [12:0] row);
        issue(3'b011, ba, row, 2'b00, 1'b0, 16'h0);
    endtask

    task automatic pre(input logic [1:0] ba, input logic all);
        issue(3'b001, ba, all ? 13'h400 : 13'h000, 2'b00, 1'b0, 16'h0);
    endtask

    task automatic refr();
        issue(3'b010, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
    endtask

    task automatic mrs(input logic [12:0] a);
        issue(3'b000, 2'd0, a, 2'b00, 1'b0, 16'h0);
    endtask

    task automatic wr(input logic [1:0] ba, input logic [8:0] col, input logic a10,
                      input logic [1:0] dqm, input logic [15:0] wd);
        issue(3'b100, ba, {3'b000, a10, 1'b0, col}, dqm, 1'b1, wd);
    endtask

    // Issue edge is cyc+1; the word is seen at the negedge after edge cyc+CL.
    task automatic rd(input logic [1:0] ba, input logic [8:0] col, input logic a10,
                      input logic [1:0] dqm, input logic expect_data, input logic [15:0] val);
        if (expect_data) exp_q.push_back('{due: cyc + tb_cl, val: val});
        issue(3'b101, ba, {3'b000, a10, 1'b0, col}, dqm, 1'b0, 16'h0);
    endtask

    task automatic init_seq(input logic [12:0] mode);
        pre(2'd0, 1'b1);
        refr();
        refr();
        mrs(mode);
    endtask

    initial begin
        rst_n = 1'b0;
        tb_oe = 1'b0;
        tb_dq = 16'h0;
        bus.clock_enable = 1'b1;
        bus.cs_n = 1'b1;
        {bus.ras_n, bus.cas_n, bus.we_n} = 3'b111;
        bus.addr = '0;
        bus.bank_addr = '0;
        {bus.data_mask_high, bus.data_mask_low} = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("reset_init_done", {7'd0, bus.init_done}, 8'h00);
        chk("reset_cl", {6'd0, bus.cas_latency}, 8'h00);
        chk("reset_err", bus.error_flags, 8'h00);
        rst_n = 1'b1;
        nop(1);

        init_seq(13'h030);
        tb_cl = 3;
        chk("init_done", {7'd0, bus.init_done}, 8'h01);
        chk("init_cl", {6'd0, bus.cas_latency}, 8'h03);
        chk("init_err", bus.error_flags, 8'h00);

        act(2'd1, 13'h005); nop(2);
        wr(2'd1, 9'h012, 1'b1, 2'b00, 16'hBEEF);
        act(2'd1, 13'h005); nop(2);
        rd(2'd1, 9'h012, 1'b0, 2'b00, 1'b1, 16'hBEEF);
        nop(4);
        pre(2'd1, 1'b0);
        chk("write_read_err", bus.error_flags, 8'h00);

        act(2'd1, 13'h005); nop(2);
        wr(2'd1, 9'h012, 1'b0, 2'b10, 16'h1234);
        nop(1);
        rd(2'd1, 9'h012, 1'b1, 2'b00, 1'b1, 16'hBE34);
        nop(4);

        act(2'd1, 13'h005); nop(2);
        rd(2'd1, 9'h012, 1'b1, 2'b01, 1'b1, 16'hBE00);
        nop(4);
        chk("masked_err", bus.error_flags, 8'h00);

        // Bank 1 was auto-precharged by the last read.
        rd(2'd1, 9'h012, 1'b0, 2'b00, 1'b0, 16'h0);
        nop(4);
        chk("closed_bank", bus.error_flags, 8'h04);

        act(2'd2, 13'h007);
        rd(2'd2, 9'h012, 1'b0, 2'b00, 1'b1, 16'hBE34);
        chk("trcd", bus.error_flags, 8'h0C);
        act(2'd2, 13'h007);
        chk("act_open", bus.error_flags, 8'h0E);
        nop(4);
        pre(2'd0, 1'b1);

        mrs(13'h020);
        tb_cl = 2;
        chk("cl2", {6'd0, bus.cas_latency}, 8'h02);
        act(2'd0, 13'h001); nop(2);
        rd(2'd0, 9'h012, 1'b1, 2'b00, 1'b1, 16'hBE34);
        nop(4);
        chk("cl2_err", bus.error_flags, 8'h0E);

        act(2'd0, 13'h001); nop(2);
        rd(2'd0, 9'h012, 1'b0, 2'b00, 1'b1, 16'hBE34);
        wr(2'd0, 9'h040, 1'b0, 2'b00, 16'h5555);
        chk("contention", bus.error_flags, 8'h8E);
        nop(3);
        pre(2'd0, 1'b0);

        act(2'd3, 13'h000);
        refr();
        chk("ref_open", bus.error_flags, 8'h9E);
        pre(2'd0, 1'b1);
        nop(999);
        chk("refresh_edge", bus.error_flags, 8'h9E);
        nop(1);
        chk("refresh_timeout", bus.error_flags, 8'hDE);

        rst_n = 1'b0;
        nop(1);
        rst_n = 1'b1;
        chk("reset2_err", bus.error_flags, 8'h00);
        act(2'd0, 13'h003);
        chk("early_act", bus.error_flags, 8'h01);
        init_seq(13'h011);
        chk("bad_mrs_err", bus.error_flags, 8'h21);
        chk("bad_mrs_done", {7'd0, bus.init_done}, 8'h01);
        chk("bad_mrs_cl", {6'd0, bus.cas_latency}, 8'h01);
        mrs(13'h030);
        tb_cl = 3;
        act(2'd1, 13'h005); nop(2);
        rd(2'd1, 9'h012, 1'b1, 2'b00, 1'b1, 16'hBE34);
        // Reset before the word reaches the bus; it must never appear.
        rst_n = 1'b0;
        exp_q.delete();
        nop(1);
        chk("midread_err", bus.error_flags, 8'h00);
        chk("midread_done", {7'd0, bus.init_done}, 8'h00);
        nop(3);
        rst_n = 1'b1;
        nop(3);

        while (exp_q.size() > 0) begin
            tests++; fails++;
            $display("FAIL dq_leftover: word 0x%04h never sampled", exp_q[0].val);
            void'(exp_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
